fetch_sequencer: RTL and testbench

//  Program-counter and fetch controller in front of the 1024x16 combinational instruction memory.

---
 rtl/fetch_sequencer_pkg.sv | 21 ++
 rtl/fetch_sequencer_if_slot_reg.sv | 56 +++++
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the fetch sequencer slice.
//   - Default widths for instruction address, instruction word and counter.
//   - state_t : sequencer FSM encoding, visible on the 'state' port as
//               00 IDLE, 01 FETCH, 10 DRAIN, 11 HALTED.
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int INSTR_W_DEF = 16;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if_slot_reg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if_slot_reg
// One-entry IF/ID register with a valid/ready handshake and a flush input.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                drop the held entry (wins over everything else)
//   load                 capture load_instr/load_pc; caller only loads when
//                        the slot is free (!valid | ready)
//   load_instr, load_pc  data to capture
//   ready                downstream consumes the entry when valid & ready
//   valid, instr, pc     held entry
// ---------------------------------------------------------------------------
import fetch_sequencer_pkg::*;

module fetch_sequencer_if_slot_reg #(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic               ready,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    logic               valid_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [ADDR_W-1:0]  pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            pc_reg    <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= load_instr;
            pc_reg    <= load_pc;
        end else if (ready) begin
            // consumed with nothing behind it; when !ready the entry holds
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign pc    = pc_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Program counter and fetch controller in front of a combinational
// instruction memory. Fetched words go into a one-entry IF/ID slot toward
// decode; branch/JALR redirects reload the pc and flush the slot.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, halt_req            run control (halt wins over start)
//   redirect_vld, redirect_pc  taken branch/JALR target
//   imem_addr / imem_instr     instruction memory address / read data
//   if_valid, if_instr, if_pc  IF/ID slot toward decode
//   if_ready                   decode accepts the slot
//   state                      00 IDLE, 01 FETCH, 10 DRAIN, 11 HALTED
//   pc_wrapped                 sticky: pc rolled over from all-ones to 0
//   fetch_cnt                  saturating count of accepted instructions
// ---------------------------------------------------------------------------
import fetch_sequencer_pkg::*;

module fetch_sequencer #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_vld,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ready,
    output logic [1:0]         state,
    output logic               pc_wrapped,
    output logic [CNT_W-1:0]   fetch_cnt
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              pc_wrapped_reg, pc_wrapped_next;
    logic [CNT_W-1:0]  fetch_cnt_reg, fetch_cnt_next;
    logic              slot_free;
    logic              fire;

    assign slot_free = !if_valid || if_ready;

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            // a redirect while stopped only moves the pc
            ST_IDLE, ST_HALTED:
                if (start && !halt_req && !redirect_vld) state_next = ST_FETCH;
            ST_FETCH:
                if (halt_req) state_next = ST_DRAIN;
            ST_DRAIN:
                if (slot_free) state_next = ST_HALTED;
            default:
                state_next = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    // The halt request cycle itself issues no fetch.
    always_comb begin
        fire = (state_reg == ST_FETCH) && slot_free && !redirect_vld && !halt_req;
    end

    // ---- pc, wrap flag and retired-fetch counter ----
    always_comb begin
        pc_next         = pc_reg;
        pc_wrapped_next = pc_wrapped_reg;
        if (redirect_vld) begin
            pc_next = redirect_pc;
        end else if (fire) begin
            pc_next = pc_reg + ADDR_W'(1);
            if (&pc_reg) pc_wrapped_next = 1'b1;
        end
    end

    always_comb begin
        fetch_cnt_next = fetch_cnt_reg;
        if (if_valid && if_ready && !(&fetch_cnt_reg))
            fetch_cnt_next = fetch_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg         <= ADDR_W'(RESET_PC);
            pc_wrapped_reg <= 1'b0;
            fetch_cnt_reg  <= '0;
        end else begin
            pc_reg         <= pc_next;
            pc_wrapped_reg <= pc_wrapped_next;
            fetch_cnt_reg  <= fetch_cnt_next;
        end
    end

    fetch_sequencer_if_slot_reg #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_if_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_vld),
        .load       (fire),
        .load_instr (imem_instr),
        .load_pc    (pc_reg),
        .ready      (if_ready),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

    assign imem_addr  = pc_reg;
    assign state      = state_reg;
    assign pc_wrapped = pc_wrapped_reg;
    assign fetch_cnt  = fetch_cnt_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Bench for fetch_sequencer. A behavioural 1024x16 memory feeds imem_instr.
// Each scenario task pushes the (pc, instr) pairs decode should accept onto
// a queue; a negedge monitor pops and compares on every handshake.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int AW = 10;
    localparam int IW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, halt_req, redirect_vld, if_ready;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_instr;
    logic          if_valid;
    logic [IW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic [1:0]    state;
    logic          pc_wrapped;
    logic [CW-1:0] fetch_cnt;

    logic [IW-1:0] mem [0:1023];

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    fetch_sequencer #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .RESET_PC (0),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .halt_req     (halt_req),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_ready     (if_ready),
        .state        (state),
        .pc_wrapped   (pc_wrapped),
        .fetch_cnt    (fetch_cnt)
    );

    // scoreboard: every decode handshake must match the next expected word
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if_valid && if_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handshake_unexpected: got pc=%0d instr=%h, required no transfer", if_pc, if_instr);
            end else begin
                e = exp_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr) begin
                    errors++;
                    $display("FAIL handshake: got pc=%0d instr=%h, required pc=%0d instr=%h", if_pc, if_instr, e.pc, e.instr);
                end else begin
                    $display("handshake pc=%0d instr=%h", if_pc, if_instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int p);
        exp_t e;
        e.pc    = AW'(p);
        e.instr = mem[p];
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (state !== 2'b00 || if_valid !== 1'b0 || imem_addr !== 10'd0) begin errors++; $display("FAIL reset_state: got state=%0d valid=%b addr=%0d, required 0/0/0", state, if_valid, imem_addr); end
        checks++; if (if_instr !== 16'h0 || if_pc !== 10'd0 || pc_wrapped !== 1'b0 || fetch_cnt !== 16'd0) begin errors++; $display("FAIL reset_slot: got instr=%h pc=%0d wrap=%b cnt=%0d, required 0", if_instr, if_pc, pc_wrapped, fetch_cnt); end
        rst_n = 1'b1;
        // start and halt together: halt wins, stay idle
        start = 1'b1; halt_req = 1'b1;
        tick();
        start = 1'b0; halt_req = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL start_halt_idle: got state=%0d, required 0", state); end
    endtask

    task automatic test_basic();
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(i);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'b01 || if_valid !== 1'b0) begin errors++; $display("FAIL basic_start: got state=%0d valid=%b, required 1/0", state, if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 10'd0 || if_instr !== mem[0]) begin errors++; $display("FAIL basic_first: got valid=%b pc=%0d instr=%h, required 1/0/%h", if_valid, if_pc, if_instr, mem[0]); end
        tick();
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL basic_drain: got state=%0d, required 2", state); end
        tick();
        checks++; if (state !== 2'b11 || fetch_cnt !== 16'd4 || imem_addr !== 10'd4) begin errors++; $display("FAIL basic_end: got state=%0d cnt=%0d addr=%0d, required 3/4/4", state, fetch_cnt, imem_addr); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_queue: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        if_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_valid !== 1'b1 || if_pc !== 10'd4 || if_instr !== mem[4] || imem_addr !== 10'd5 || fetch_cnt !== 16'd4) begin errors++; $display("FAIL stall_hold: got valid=%b pc=%0d instr=%h addr=%0d cnt=%0d, required 1/4/%h/5/4", if_valid, if_pc, if_instr, imem_addr, fetch_cnt, mem[4]); end
        end
        push_exp(4); push_exp(5); push_exp(6);
        if_ready = 1'b1;
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        checks++; if (state !== 2'b11 || fetch_cnt !== 16'd7 || imem_addr !== 10'd7) begin errors++; $display("FAIL stall_end: got state=%0d cnt=%0d addr=%0d, required 3/7/7", state, fetch_cnt, imem_addr); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_queue: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        if_ready = 1'b1;
        push_exp(7);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        // slot holds pc 8, not accepted; redirect must flush it anyway
        if_ready = 1'b0;
        redirect_vld = 1'b1; redirect_pc = 10'd7;
        tick();
        redirect_vld = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_addr !== 10'd7 || state !== 2'b01) begin errors++; $display("FAIL redirect_flush: got valid=%b addr=%0d state=%0d, required 0/7/1", if_valid, imem_addr, state); end
        if_ready = 1'b1;
        push_exp(7); push_exp(8);
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 10'd7 || if_instr !== mem[7]) begin errors++; $display("FAIL redirect_target: got valid=%b pc=%0d instr=%h, required 1/7/%h", if_valid, if_pc, if_instr, mem[7]); end
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        checks++; if (state !== 2'b11 || fetch_cnt !== 16'd10) begin errors++; $display("FAIL redirect_cnt: got state=%0d cnt=%0d, required 3/10", state, fetch_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redirect_queue: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        redirect_vld = 1'b1; redirect_pc = 10'd1022;
        tick();
        redirect_vld = 1'b0;
        checks++; if (state !== 2'b11 || imem_addr !== 10'd1022 || pc_wrapped !== 1'b0) begin errors++; $display("FAIL wrap_redirect_halted: got state=%0d addr=%0d wrap=%b, required 3/1022/0", state, imem_addr, pc_wrapped); end
        if_ready = 1'b1;
        push_exp(1022); push_exp(1023); push_exp(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (pc_wrapped !== 1'b0) begin errors++; $display("FAIL wrap_early: got wrap=%b, required 0", pc_wrapped); end
        tick();
        checks++; if (pc_wrapped !== 1'b1 || imem_addr !== 10'd0) begin errors++; $display("FAIL wrap_set: got wrap=%b addr=%0d, required 1/0", pc_wrapped, imem_addr); end
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        checks++; if (fetch_cnt !== 16'd13 || pc_wrapped !== 1'b1 || imem_addr !== 10'd1) begin errors++; $display("FAIL wrap_end: got cnt=%0d wrap=%b addr=%0d, required 13/1/1", fetch_cnt, pc_wrapped, imem_addr); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_queue: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_halt_drain();
        if_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++; if (state !== 2'b10 || if_valid !== 1'b1 || if_pc !== 10'd1) begin errors++; $display("FAIL drain_enter: got state=%0d valid=%b pc=%0d, required 2/1/1", state, if_valid, if_pc); end
        tick();
        tick();
        checks++; if (state !== 2'b10 || imem_addr !== 10'd2) begin errors++; $display("FAIL drain_hold: got state=%0d addr=%0d, required 2/2", state, imem_addr); end
        push_exp(1);
        if_ready = 1'b1;
        tick();
        checks++; if (state !== 2'b11 || if_valid !== 1'b0 || fetch_cnt !== 16'd14) begin errors++; $display("FAIL drain_halted: got state=%0d valid=%b cnt=%0d, required 3/0/14", state, if_valid, fetch_cnt); end
        tick();
        checks++; if (imem_addr !== 10'd2) begin errors++; $display("FAIL halted_pc: got addr=%0d, required 2", imem_addr); end
        push_exp(2); push_exp(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 10'd2) begin errors++; $display("FAIL resume: got valid=%b pc=%0d, required 1/2", if_valid, if_pc); end
        tick();
        tick();
        checks++; if (imem_addr !== 10'd5 || fetch_cnt !== 16'd16) begin errors++; $display("FAIL resume_run: got addr=%0d cnt=%0d, required 5/16", imem_addr, fetch_cnt); end
    endtask

    task automatic test_async_reset();
        // pc is 5 with pc 4 in the slot; reset lands between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'b00 || if_valid !== 1'b0 || imem_addr !== 10'd0 || fetch_cnt !== 16'd0) begin errors++; $display("FAIL async_reset: got state=%0d valid=%b addr=%0d cnt=%0d, required 0/0/0/0", state, if_valid, imem_addr, fetch_cnt); end
        checks++; if (if_instr !== 16'h0 || if_pc !== 10'd0 || pc_wrapped !== 1'b0) begin errors++; $display("FAIL async_reset_slot: got instr=%h pc=%0d wrap=%b, required 0/0/0", if_instr, if_pc, pc_wrapped); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (state !== 2'b00 || if_valid !== 1'b0) begin errors++; $display("FAIL post_reset: got state=%0d valid=%b, required 0/0", state, if_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = IW'((i * 40503) ^ 32'h5A5A);
        rst_n = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt_drain();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
